// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers: radix-2 shift-add
// multiply and restoring divide on sign magnitudes, with a final sign-fix cycle.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             is_unsigned,
    input  logic             write_hi,
    input  logic             write_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag1, mag2;
    logic               sign1, sign2, op_div;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic               sign1_in, sign2_in;
    logic [WIDTH-1:0]   mag1_in, mag2_in;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] step_acc, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // acc holds {upper, lower}: multiply keeps the multiplier in the lower half and
    // shifts right; divide keeps the dividend/quotient there and shifts left.
    // NOTE: every always_comb output gets a default up front so no latch is inferred.
    always_comb begin
        sign1_in = !is_unsigned && op1[WIDTH-1];
        sign2_in = !is_unsigned && op2[WIDTH-1];
        mag1_in  = sign1_in ? -op1 : op1;
        mag2_in  = sign2_in ? -op2 : op2;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag1} : '0);
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag2};
        step_acc = {mul_sum, acc[WIDTH-1:1]};
        if (state == S_DIV) begin
            step_acc = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        prod_fix = (sign1 ^ sign2) ? -acc : acc;
        quo_fix  = (sign1 ^ sign2) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign1 ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mag1   <= '0;
            mag2   <= '0;
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            op_div <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (write_hi) hi_q <= op1;
                    if (write_lo) lo_q <= op1;
                    if (start_mul || start_div) begin
                        sign1  <= sign1_in;
                        sign2  <= sign2_in;
                        mag1   <= mag1_in;
                        mag2   <= mag2_in;
                        op_div <= !start_mul;
                        acc    <= start_mul ? {{WIDTH{1'b0}}, mag2_in} : {{WIDTH{1'b0}}, mag1_in};
                        cnt    <= '0;
                        dbz_q  <= 1'b0;
                        state  <= start_mul ? S_MUL : S_DIV;
                    end
                end
                S_MUL: begin
                    acc <= step_acc;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
                end
                S_DIV: begin
                    if (mag2 == '0) begin
                        done_q <= 1'b1;
                        dbz_q  <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
                    end
                end
                default: begin
                    if (op_div) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: hand-computed HI/LO results, latency,
// divide-by-zero, ignored starts/writes while busy, and mid-operation reset.
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] op1, op2;
    logic        start_mul, start_div, is_unsigned, write_hi, write_lo;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

    muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2),
        .start_mul(start_mul), .start_div(start_div), .is_unsigned(is_unsigned),
        .write_hi(write_hi), .write_lo(write_lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Starts an op, then checks busy through edge 32, the commit at edge 33, and done dropping.
    task automatic run_op(input logic mul, input logic uns, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        op1 = a; op2 = b; is_unsigned = uns;
        start_mul = mul; start_div = !mul;
        tick();
        start_mul = 1'b0; start_div = 1'b0;
        check({tag, ".busy_e0"}, busy, 1);
        check({tag, ".dbz_e0"}, div_by_zero, 0);
        for (int i = 1; i < 32; i++) tick();
        tick();
        check({tag, ".busy_e32"}, {busy, done}, 2'b10);
        tick();
        check({tag, ".done_e33"}, {busy, done}, 2'b01);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        tick();
        check({tag, ".done_drop"}, done, 0);
    endtask

    initial begin
        rst_n = 1'b0; op1 = '0; op2 = '0;
        start_mul = 1'b0; start_div = 1'b0; is_unsigned = 1'b0;
        write_hi = 1'b0; write_lo = 1'b0;
        tick(); tick();
        check("reset", {busy, done, div_by_zero, hi, lo}, '0);
        rst_n = 1'b1;
        tick();

        run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "smul_m3x7");
        run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "umul_max");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, "smul_m1xm1");
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "sdiv_m7d2");
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, "udiv_100d7");
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "sdiv_min");

        // Both writes in one cycle load op1.
        op1 = 32'h0000_A5A5; write_hi = 1'b1; write_lo = 1'b1;
        tick();
        write_hi = 1'b0; write_lo = 1'b0;
        check("write_both", {hi, lo}, {32'h0000_A5A5, 32'h0000_A5A5});

        // Divide by zero after preloading hi.
        op1 = 32'h0000_1234; write_hi = 1'b1;
        tick();
        write_hi = 1'b0;
        check("preload_hi", hi, 32'h0000_1234);
        op1 = 32'd5; op2 = 32'd0; is_unsigned = 1'b0; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        check("dz.busy_e0", {busy, done, div_by_zero}, 3'b100);
        tick();
        check("dz.flags_e1", {busy, done, div_by_zero}, 3'b011);
        check("dz.hilo", {hi, lo}, {32'h0000_1234, 32'h0000_A5A5});
        tick();
        check("dz.hold", {done, div_by_zero}, 2'b01);

        // Start-while-busy and write_lo-while-busy are ignored; 1000/3 = 333 r 1.
        op1 = 32'd1000; op2 = 32'd3; is_unsigned = 1'b1; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        check("ign.dbz_clr", div_by_zero, 0);
        for (int i = 1; i < 10; i++) tick();
        op1 = 32'h0000_DEAD; op2 = 32'd5; start_div = 1'b1; write_lo = 1'b1;
        tick();
        start_div = 1'b0; write_lo = 1'b0;
        check("ign.lo_kept", lo, 32'h0000_A5A5);
        for (int i = 11; i < 33; i++) tick();
        check("ign.busy_e32", {busy, done}, 2'b10);
        tick();
        check("ign.done_e33", {busy, done}, 2'b01);
        check("ign.result", {hi, lo}, {32'd1, 32'd333});
        tick();
        check("ign.no_second", {busy, done}, 2'b00);

        // Reset in the middle of a multiply, then a clean multiply.
        op1 = 32'd9; op2 = 32'd9; is_unsigned = 1'b1; start_mul = 1'b1;
        tick();
        start_mul = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid", {busy, done, div_by_zero, hi, lo}, '0);
        tick();
        check("rst_no_done", {busy, done}, 2'b00);
        run_op(1'b1, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42, "umul_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO architectural registers.
- Sits directly downstream of the single-cycle ALU in the execute stage and replaces the ALU's combinational multiply/divide.
- Takes the same op1/op2 operands and control strobes, runs an iterative shift-add multiply or restoring divide, and writes HI/LO.
- Asserts busy so the pipeline controller can stall a later MFHI/MFLO or a new mul/div.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
op1  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
op2  in  WIDTH  multiplier / divisor
start_mul  in  1  start multiply (MULT/MULTU)
start_div  in  1  start divide (DIV/DIVU)
is_unsigned  in  1  1 = unsigned operation, 0 = two's-complement
write_hi  in  1  HI <= op1 (MTHI)
write_lo  in  1  LO <= op1 (MTLO)
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO results are committed
div_by_zero  out  1  last divide had op2 == 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low, sampled only on the rising edge of `clk`.
- Reset (rst_n low at a rising edge, including mid-operation):
  - State goes to IDLE.
  - hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0.
  - Any in-flight result is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start acceptance:
  - start_mul or start_div is sampled only in IDLE.
  - If both are high, start_mul wins.
  - On the accepting edge (edge 0), the unit latches operand magnitudes, sign flags (forced 0 when is_unsigned), and op type; clears the counter; clears div_by_zero; sets busy = 1.
  - Signed magnitudes: |x| = two's-complement negate of x when x[31] = 1. |0x80000000| = 0x80000000 as unsigned.
- MUL:
  - One radix-2 shift-add step per cycle on a 2*WIDTH accumulator.
  - After 32 steps (edges 1..32), go to FIX.
- DIV:
  - If the latched divisor is 0, at edge 1: go to IDLE, busy = 0, done = 1, div_by_zero = 1. hi and lo are unchanged.
  - Otherwise, one restoring step per cycle (shift the remainder left, subtract the divisor, keep the result if non-negative, shift in the quotient bit). After 32 steps, go to FIX.
- FIX (edge 33):
  - Multiply: product negated if sign1 ^ sign2; hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient negated if sign1 ^ sign2; hi = remainder negated if sign1 (remainder takes the sign of the dividend; truncation toward zero).
  - Then go to IDLE, busy = 0, done = 1.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Latency:
  - Non-zero operation: busy is high for 33 cycles, and results are visible after edge 33 of the start edge.
  - Divide by zero: 1 cycle.
- done is high for exactly one cycle and otherwise 0. div_by_zero holds until the next accepted start or reset.
- Starts while busy: start_mul/start_div are ignored, with no queueing. The controller is responsible for stalling.
- write_hi/write_lo:
  - Applied only when not busy; ignored when busy.
  - If asserted together with an accepted start, the write lands at edge 0 and the operation result overwrites it at completion.
  - write_hi and write_lo in the same cycle both load op1.
- hi and lo change only on: reset, write_hi/write_lo, or FIX commit.

Test Plan:
- Signed mul op1=0xFFFFFFFD (-3), op2=7 -> after 33 cycles busy falls, done pulses; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned mul 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with is_unsigned=0 -> hi=0, lo=1.
- Signed div -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned div 100/7 -> lo=14, hi=2.
- Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Div by zero: preload hi=0x1234 via write_hi, divide 5/0 -> one cycle later done=1, div_by_zero=1, hi still 0x1234.
- Start while busy: second start_div at cycle 10 is ignored; write_lo during busy is ignored; the result matches the first op only.
- rst_n low at cycle 15 of a multiply -> next cycle busy=0, hi=lo=0, no done pulse; a new mul started afterwards completes correctly.
